// File: rtl/nonce_dispatcher.sv
// -----------------------------------------------------------------------------
// nonce_dispatcher
// Job-level sequencer placed in front of the miner core control unit. It accepts
// a job (inclusive nonce range plus a hash target) and issues one hash_enable
// pulse per nonce. After each pulse it waits for the core's finished strobe and
// compares the returned hash against the target. It stops on a winning nonce,
// an exhausted range, an abort or a core timeout, and then reports exactly one
// result per job over a valid/ready handshake.
//
// Ports
//   clk              system clock, rising edge
//   n_rst            asynchronous reset, ACTIVE-HIGH despite the name
//   job_valid        new job offered
//   job_ready        job accepted when high (IDLE only)
//   job_nonce_start  first nonce to try
//   job_nonce_end    last nonce to try (inclusive)
//   job_target       winning hash must be strictly below this value
//   abort            terminate the current job
//   hash_enable      one-cycle start pulse to the miner core
//   nonce_out        nonce under test, stable from hash_enable until CHECK
//   finished         core done strobe
//   hash_in          core result, valid while finished=1
//   result_valid     result available (DONE)
//   result_ready     consumer accepts the result
//   result_found     a winning nonce was found
//   result_nonce     winning nonce, else the last nonce tried
//   result_status    00 ok/exhausted, 01 aborted, 10 timeout
//   busy             high in every state except IDLE
// -----------------------------------------------------------------------------
module nonce_dispatcher #(
   parameter int NONCE_W     = 32,
   parameter int HASH_W      = 256,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [NONCE_W-1:0] job_nonce_start,
   input  logic [NONCE_W-1:0] job_nonce_end,
   input  logic [HASH_W-1:0]  job_target,
   input  logic               abort,
   output logic               hash_enable,
   output logic [NONCE_W-1:0] nonce_out,
   input  logic               finished,
   input  logic [HASH_W-1:0]  hash_in,
   output logic               result_valid,
   input  logic               result_ready,
   output logic               result_found,
   output logic [NONCE_W-1:0] result_nonce,
   output logic [1:0]         result_status,
   output logic               busy
);

   localparam int               TMR_W       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TIMEOUT_VAL = TMR_W'(TIMEOUT_CYC);

   localparam logic [1:0] STAT_OK      = 2'b00;
   localparam logic [1:0] STAT_ABORT   = 2'b01;
   localparam logic [1:0] STAT_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CHECK,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [NONCE_W-1:0] cur_q, cur_d;
   logic [NONCE_W-1:0] end_q, end_d;
   logic [HASH_W-1:0]  target_q, target_d;
   logic [HASH_W-1:0]  hash_q, hash_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               found_q, found_d;
   logic [NONCE_W-1:0] res_nonce_q, res_nonce_d;
   logic [1:0]         status_q, status_d;

   // timer_q counts the WAIT/DRAIN cycles already spent for the current pulse,
   // so the job gives up after TIMEOUT_CYC cycles without finished; a finished
   // arriving on the last allowed cycle is still honoured.
   logic [TMR_W-1:0] timer_inc;
   logic             timeout;

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      end_d       = end_q;
      target_d    = target_q;
      hash_d      = hash_q;
      timer_d     = timer_q;
      found_d     = found_q;
      res_nonce_d = res_nonce_q;
      status_d    = status_q;

      timer_inc = timer_q + 1'b1;
      timeout   = (timer_inc == TIMEOUT_VAL);

      case (state_q)
         S_IDLE: begin
            if (job_valid) begin
               cur_d    = job_nonce_start;
               end_d    = job_nonce_end;
               target_d = job_target;
               if (job_nonce_start > job_nonce_end) begin
                  // Empty range: report immediately without touching the core.
                  state_d     = S_DONE;
                  found_d     = 1'b0;
                  status_d    = STAT_OK;
                  res_nonce_d = job_nonce_start;
               end else begin
                  state_d = S_START;
               end
            end
         end

         S_START: begin
            timer_d = '0;
            if (abort) begin
               state_d     = S_DONE;
               found_d     = 1'b0;
               status_d    = STAT_ABORT;
               res_nonce_d = cur_q;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            timer_d = timer_inc;
            if (abort) begin
               found_d     = 1'b0;
               status_d    = STAT_ABORT;
               res_nonce_d = cur_q;
               // If the core is already done (or given up on) this cycle there
               // is nothing left to drain; otherwise wait for it to go idle.
               state_d = (finished || timeout) ? S_DONE : S_DRAIN;
            end else if (finished) begin
               hash_d  = hash_in;
               state_d = S_CHECK;
            end else if (timeout) begin
               state_d     = S_DONE;
               found_d     = 1'b0;
               status_d    = STAT_TIMEOUT;
               res_nonce_d = cur_q;
            end
         end

         S_CHECK: begin
            if (abort) begin
               state_d     = S_DONE;
               found_d     = 1'b0;
               status_d    = STAT_ABORT;
               res_nonce_d = cur_q;
            end else if (hash_q < target_q) begin
               state_d     = S_DONE;
               found_d     = 1'b1;
               status_d    = STAT_OK;
               res_nonce_d = cur_q;
            end else if (cur_q == end_q) begin
               // Tested before the increment so an all-ones end never wraps.
               state_d     = S_DONE;
               found_d     = 1'b0;
               status_d    = STAT_OK;
               res_nonce_d = cur_q;
            end else begin
               cur_d   = cur_q + 1'b1;
               state_d = S_START;
            end
         end

         S_DRAIN: begin
            // Result fields were set on entry; the hash is discarded.
            timer_d = timer_inc;
            if (finished || timeout) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            if (result_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         end_q       <= '0;
         target_q    <= '0;
         hash_q      <= '0;
         timer_q     <= '0;
         found_q     <= 1'b0;
         res_nonce_q <= '0;
         status_q    <= STAT_OK;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         end_q       <= end_d;
         target_q    <= target_d;
         hash_q      <= hash_d;
         timer_q     <= timer_d;
         found_q     <= found_d;
         res_nonce_q <= res_nonce_d;
         status_q    <= status_d;
      end
   end

   assign job_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign hash_enable   = (state_q == S_START);
   assign nonce_out     = cur_q;
   assign result_valid  = (state_q == S_DONE);
   assign result_found  = found_q;
   assign result_nonce  = res_nonce_q;
   assign result_status = status_q;

endmodule
